// File: rtl/banco_registros_param_if.sv
// Register file bus: writeback, issue/scoreboard and two read ports.
// Widths follow XLEN and NREGS; AW is the register address width.
interface banco_registros_param_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            wren_i;
  logic [AW-1:0]   rd_i;
  logic [XLEN-1:0] datard_i;
  logic [AW-1:0]   rs1_i;
  logic [AW-1:0]   rs2_i;
  logic [XLEN-1:0] datars1_o;
  logic [XLEN-1:0] datars2_o;
  logic            issue_i;
  logic [AW-1:0]   issue_rd_i;
  logic            busy1_o;
  logic            busy2_o;
  logic            hazard_o;

  modport master (
    output wren_i, rd_i, datard_i,
    output rs1_i, rs2_i,
    output issue_i, issue_rd_i,
    input  datars1_o, datars2_o,
    input  busy1_o, busy2_o, hazard_o
  );

  modport slave (
    input  wren_i, rd_i, datard_i,
    input  rs1_i, rs2_i,
    input  issue_i, issue_rd_i,
    output datars1_o, datars2_o,
    output busy1_o, busy2_o, hazard_o
  );
endinterface

// File: rtl/banco_registros_param.sv
// Parameterised register file with x0 hardwired to zero, optional
// write-to-read bypass and a per-register pending scoreboard.
module banco_registros_param #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input logic clk_i,
  input logic rst_i,
  banco_registros_param_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_n;
  logic             wr_ok;
  logic             iss_ok;
  logic             fwd1;
  logic             fwd2;

  assign wr_ok  = bus.wren_i && (bus.rd_i != '0);
  assign iss_ok = bus.issue_i && (bus.issue_rd_i != '0);

  // Issue is applied after the clear so a same-edge re-issue wins.
  always_comb begin
    pend_n = pend;
    if (wr_ok)
      pend_n[bus.rd_i] = 1'b0;
    if (iss_ok)
      pend_n[bus.issue_rd_i] = 1'b1;
    pend_n[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      pend <= '0;
    end else begin
      if (wr_ok)
        regs[bus.rd_i] <= bus.datard_i;
      pend <= pend_n;
    end
  end

  assign fwd1 = BYP && wr_ok
             && (bus.rd_i == bus.rs1_i);
  assign fwd2 = BYP && wr_ok
             && (bus.rd_i == bus.rs2_i);

  always_comb begin
    bus.datars1_o = '0;
    if (bus.rs1_i != '0)
      bus.datars1_o = fwd1 ? bus.datard_i
                           : regs[bus.rs1_i];
  end

  always_comb begin
    bus.datars2_o = '0;
    if (bus.rs2_i != '0)
      bus.datars2_o = fwd2 ? bus.datard_i
                           : regs[bus.rs2_i];
  end

  assign bus.busy1_o  = pend[bus.rs1_i] && !fwd1;
  assign bus.busy2_o  = pend[bus.rs2_i] && !fwd2;
  assign bus.hazard_o = bus.busy1_o || bus.busy2_o;

  logic unused;
  assign unused = ^{AW[0]};
endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench: bypass and no-bypass 32x32 instances share stimulus,
// a 64-bit 16-entry instance checks width and top address.
module tb_banco_registros_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  banco_registros_param_if #(.XLEN(32), .NREGS(32)) ba ();
  banco_registros_param_if #(.XLEN(32), .NREGS(32)) bb ();
  banco_registros_param_if #(.XLEN(64), .NREGS(16)) bc ();

  assign bb.wren_i     = ba.wren_i;
  assign bb.rd_i       = ba.rd_i;
  assign bb.datard_i   = ba.datard_i;
  assign bb.rs1_i      = ba.rs1_i;
  assign bb.rs2_i      = ba.rs2_i;
  assign bb.issue_i    = ba.issue_i;
  assign bb.issue_rd_i = ba.issue_rd_i;

  banco_registros_param #(
    .XLEN(32), .NREGS(32), .BYPASS(1)
  ) u_a (.clk_i(clk), .rst_i(rst), .bus(ba));

  banco_registros_param #(
    .XLEN(32), .NREGS(32), .BYPASS(0)
  ) u_b (.clk_i(clk), .rst_i(rst), .bus(bb));

  banco_registros_param #(
    .XLEN(64), .NREGS(16), .BYPASS(1)
  ) u_c (.clk_i(clk), .rst_i(rst), .bus(bc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ba.wren_i = 0; ba.rd_i = 0; ba.datard_i = 0;
    ba.rs1_i = 0; ba.rs2_i = 0;
    ba.issue_i = 0; ba.issue_rd_i = 0;
    bc.wren_i = 0; bc.rd_i = 0; bc.datard_i = 0;
    bc.rs1_i = 0; bc.rs2_i = 0;
    bc.issue_i = 0; bc.issue_rd_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    ba.wren_i = 1; ba.rd_i = 6; ba.datard_i = 32'h55;
    ba.issue_i = 1; ba.issue_rd_i = 8;
    step();
    rst = 0;
    idle();
    for (int i = 0; i < 32; i += 3) begin
      ba.rs1_i = 5'(i); ba.rs2_i = 5'(31 - i);
      #1;
      total++;
      if ({ba.datars1_o, ba.datars2_o} !== 64'h0) begin
        bad++;
        $display("FAIL reset_data a i=%0d got %h/%h exp 0/0",
                 i, ba.datars1_o, ba.datars2_o);
      end
      total++;
      if ({ba.busy1_o, ba.busy2_o, ba.hazard_o,
           bb.busy1_o, bb.busy2_o, bb.hazard_o} !== 6'b0) begin
        bad++;
        $display("FAIL reset_busy i=%0d got %b%b%b exp 000", i,
                 ba.busy1_o, ba.busy2_o, ba.hazard_o);
      end
      total++;
      if ({bb.datars1_o, bb.datars2_o} !== 64'h0) begin
        bad++;
        $display("FAIL reset_data b i=%0d got %h/%h exp 0/0",
                 i, bb.datars1_o, bb.datars2_o);
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    ba.wren_i = 1; ba.rd_i = 5; ba.datard_i = 32'hDEADBEEF;
    step();
    idle();
    ba.rs1_i = 5; ba.rs2_i = 0;
    #1;
    total++;
    if (ba.datars1_o !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_rs1 got %h exp deadbeef", ba.datars1_o);
    end
    total++;
    if (ba.datars2_o !== 32'h0) begin
      bad++;
      $display("FAIL wr_rs2_x0 got %h exp 0", ba.datars2_o);
    end
    total++;
    if (bb.datars1_o !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_rs1_b got %h exp deadbeef", bb.datars1_o);
    end
  endtask

  task automatic test_bypass();
    idle();
    ba.wren_i = 1; ba.rd_i = 7; ba.datard_i = 32'h12345678;
    ba.rs1_i = 7; ba.rs2_i = 7;
    #1;
    total++;
    if ({ba.datars1_o, ba.datars2_o} !== {2{32'h12345678}}) begin
      bad++;
      $display("FAIL byp_same got %h/%h exp 12345678",
               ba.datars1_o, ba.datars2_o);
    end
    total++;
    if ({bb.datars1_o, bb.datars2_o} !== 64'h0) begin
      bad++;
      $display("FAIL nobyp_old got %h/%h exp 0/0",
               bb.datars1_o, bb.datars2_o);
    end
    step();
    idle();
    ba.rs1_i = 7; ba.rs2_i = 7;
    #1;
    total++;
    if ({bb.datars1_o, bb.datars2_o} !== {2{32'h12345678}}) begin
      bad++;
      $display("FAIL nobyp_next got %h/%h exp 12345678",
               bb.datars1_o, bb.datars2_o);
    end
    // port 1 bypasses, port 2 reads stored x5
    ba.wren_i = 1; ba.rd_i = 7; ba.datard_i = 32'hCAFE0001;
    ba.rs1_i = 7; ba.rs2_i = 5;
    #1;
    total++;
    if ({ba.datars1_o, ba.datars2_o}
        !== {32'hCAFE0001, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL byp_indep got %h/%h exp cafe0001/deadbeef",
               ba.datars1_o, ba.datars2_o);
    end
    step();
  endtask

  task automatic test_pending();
    idle();
    ba.issue_i = 1; ba.issue_rd_i = 3;
    step();
    idle();
    ba.rs1_i = 3;
    #1;
    total++;
    if ({ba.busy1_o, ba.hazard_o} !== 2'b11) begin
      bad++;
      $display("FAIL pend_set got %b%b exp 11",
               ba.busy1_o, ba.hazard_o);
    end
    ba.wren_i = 1; ba.rd_i = 3; ba.datard_i = 32'h33;
    #1;
    total++;
    if ({ba.busy1_o, ba.hazard_o} !== 2'b00) begin
      bad++;
      $display("FAIL pend_byp got %b%b exp 00",
               ba.busy1_o, ba.hazard_o);
    end
    total++;
    if ({bb.busy1_o, bb.hazard_o} !== 2'b11) begin
      bad++;
      $display("FAIL pend_nobyp got %b%b exp 11",
               bb.busy1_o, bb.hazard_o);
    end
    step();
    idle();
    ba.rs1_i = 3; ba.rs2_i = 3;
    #1;
    total++;
    if ({ba.busy1_o, ba.busy2_o, bb.busy1_o, bb.busy2_o}
        !== 4'b0) begin
      bad++;
      $display("FAIL pend_clr got %b%b%b%b exp 0000",
               ba.busy1_o, ba.busy2_o, bb.busy1_o, bb.busy2_o);
    end
  endtask

  task automatic test_same_edge();
    idle();
    ba.issue_i = 1; ba.issue_rd_i = 9;
    ba.wren_i = 1; ba.rd_i = 9; ba.datard_i = 32'hA5;
    step();
    idle();
    ba.rs2_i = 9;
    #1;
    total++;
    if ({ba.datars2_o, ba.busy2_o, ba.hazard_o}
        !== {32'hA5, 2'b11}) begin
      bad++;
      $display("FAIL set_wins got %h %b%b exp a5 11",
               ba.datars2_o, ba.busy2_o, ba.hazard_o);
    end
    ba.issue_i = 1; ba.issue_rd_i = 9;
    step();
    idle();
    ba.rs2_i = 9;
    #1;
    total++;
    if (ba.busy2_o !== 1'b1) begin
      bad++;
      $display("FAIL reissue got %b exp 1", ba.busy2_o);
    end
    ba.wren_i = 1; ba.rd_i = 0; ba.datard_i = 32'hFFFF;
    ba.issue_i = 1; ba.issue_rd_i = 0;
    step();
    idle();
    #1;
    total++;
    if ({ba.datars1_o, ba.busy1_o, bb.datars1_o, bb.busy1_o}
        !== 66'h0) begin
      bad++;
      $display("FAIL x0_ignore got %h %b exp 0 0",
               ba.datars1_o, ba.busy1_o);
    end
    ba.issue_i = 1; ba.issue_rd_i = 10;
    ba.wren_i = 1; ba.rd_i = 11; ba.datard_i = 32'hB11;
    step();
    idle();
    ba.rs1_i = 10; ba.rs2_i = 11;
    #1;
    total++;
    if ({ba.busy1_o, ba.busy2_o, ba.datars2_o}
        !== {2'b10, 32'hB11}) begin
      bad++;
      $display("FAIL diff_regs got %b%b %h exp 10 b11",
               ba.busy1_o, ba.busy2_o, ba.datars2_o);
    end
  endtask

  task automatic test_mid_reset();
    idle();
    ba.issue_i = 1; ba.issue_rd_i = 4;
    ba.wren_i = 1; ba.rd_i = 6; ba.datard_i = 32'h66;
    step();
    rst = 1;
    ba.issue_i = 1; ba.issue_rd_i = 8;
    ba.wren_i = 1; ba.rd_i = 6; ba.datard_i = 32'h77;
    step();
    rst = 0;
    idle();
    ba.rs1_i = 6; ba.rs2_i = 4;
    #1;
    total++;
    if ({ba.datars1_o, ba.busy1_o, ba.busy2_o, ba.hazard_o}
        !== 35'h0) begin
      bad++;
      $display("FAIL midrst_a got %h %b%b%b exp 0 000",
               ba.datars1_o, ba.busy1_o, ba.busy2_o, ba.hazard_o);
    end
    ba.rs1_i = 8; ba.rs2_i = 9;
    #1;
    total++;
    if ({ba.busy1_o, ba.busy2_o, bb.busy1_o, bb.busy2_o,
         ba.datars2_o} !== 36'h0) begin
      bad++;
      $display("FAIL midrst_busy got %b%b %h exp 00 0",
               ba.busy1_o, ba.busy2_o, ba.datars2_o);
    end
  endtask

  task automatic test_wide();
    idle();
    bc.wren_i = 1; bc.rd_i = 15; bc.datard_i = '1;
    step();
    bc.rd_i = 1; bc.datard_i = 64'h0123_4567_89AB_CDEF;
    step();
    idle();
    bc.rs1_i = 15; bc.rs2_i = 1;
    #1;
    total++;
    if (bc.datars1_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++;
      $display("FAIL wide_x15 got %h exp all ones", bc.datars1_o);
    end
    total++;
    if (bc.datars2_o !== 64'h0123_4567_89AB_CDEF) begin
      bad++;
      $display("FAIL wide_x1 got %h exp 0123456789abcdef",
               bc.datars2_o);
    end
    bc.rs1_i = 0; bc.rs2_i = 14;
    #1;
    total++;
    if ({bc.datars1_o, bc.datars2_o} !== 128'h0) begin
      bad++;
      $display("FAIL wide_x0_x14 got %h/%h exp 0/0",
               bc.datars1_o, bc.datars2_o);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_pending();
    test_same_edge();
    test_mid_reset();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
